fir_mac_multich: RTL and testbench

Parametrised serial-MAC FIR filter, the successor to the fixed 64-tap single-channel FIR. Supports a configurable tap count, N time-multiplexed channels with independent delay lines, and a shared coefficient set loadable at run time. Uses valid/ready handshakes on both input and output so the block can sit between a streaming ADC front-end and a backpressuring consumer.

---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_mac_multich_if.sv | 39 +++
 rtl/fir_mac_ctrl.sv | 94 +++++++++
 rtl/fir_mac_multich.sv | 114 +++++++++++
 tb/tb_fir_mac_multich.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and width helpers for the multichannel serial-MAC FIR.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Smallest output width that cannot overflow for a full-length sum.
  function automatic int fir_out_w(input int in_w, input int coef_w, input int taps);
    return in_w + coef_w + $clog2(taps);
  endfunction

  // Channel-select width, never narrower than one bit.
  function automatic int chan_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Tap counter has to reach TAPS itself (the output-load step).
  function automatic int cnt_w(input int taps);
    return $clog2(taps + 1);
  endfunction

  localparam int DEF_TAPS  = 64;
  localparam int DEF_CNT_W = $clog2(DEF_TAPS + 1);
  localparam int DEF_ADR_W = $clog2(DEF_TAPS);

endpackage

// File: rtl/fir_mac_multich_if.sv
// Sample, coefficient and result handshakes of the multichannel FIR.
interface fir_mac_multich_if
  import fir_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int COEF_W   = 16,
  parameter int TAPS     = 64,
  parameter int CHANNELS = 2,
  parameter int OUT_W    = 38
);
  localparam int CH_W = chan_w(CHANNELS);
  localparam int AW   = $clog2(TAPS);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [IN_W-1:0]   in_data;
  logic [CH_W-1:0]          in_chan;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_ready;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic [CH_W-1:0]          out_chan;
  logic                     chan_err;

  modport slave (
    input  in_valid, in_data, in_chan, coef_we, coef_addr, coef_data, flush, out_ready,
    output in_ready, coef_ready, out_valid, out_data, out_chan, chan_err
  );

  modport master (
    output in_valid, in_data, in_chan, coef_we, coef_addr, coef_data, flush, out_ready,
    input  in_ready, coef_ready, out_valid, out_data, out_chan, chan_err
  );

endinterface

// File: rtl/fir_mac_ctrl.sv
// Control FSM: sequences IDLE/MAC/OUT, runs the tap counter and the handshakes.
module fir_mac_ctrl
  import fir_pkg::*;
#(
  parameter int TAPS  = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             chan_ok,
  input  logic             coef_we,
  input  logic             flush,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             coef_ready,
  output logic             out_valid,
  output logic             chan_err,
  output logic             accept,
  output logic             coef_wr,
  output logic             flush_en,
  output logic             mac_en,
  output logic             load_out,
  output logic [CNT_W-1:0] k
);

  state_t state, state_n;
  logic   drop;

  // State register; reset aborts any computation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Tap counter: cleared on sample accept, advanced on every MAC step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        k <= '0;
    else if (accept) k <= '0;
    else if (mac_en) k <= k + CNT_W'(1);
  end

  // One-cycle error pulse for a dropped bad-channel sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chan_err <= 1'b0;
    else      chan_err <= drop;
  end

  // Next state and strobes; flush beats coef write beats sample in IDLE.
  always_comb begin
    state_n    = state;
    in_ready   = 1'b0;
    coef_ready = 1'b0;
    accept     = 1'b0;
    drop       = 1'b0;
    coef_wr    = 1'b0;
    flush_en   = 1'b0;
    mac_en     = 1'b0;
    load_out   = 1'b0;
    out_valid  = (state == OUT);
    case (state)
      IDLE: begin
        in_ready   = 1'b1;
        coef_ready = 1'b1;
        if (flush) begin
          flush_en = 1'b1;
        end else begin
          coef_wr = coef_we;
          if (in_valid) begin
            if (chan_ok) begin
              accept  = 1'b1;
              state_n = MAC;
            end else begin
              drop = 1'b1;
            end
          end
        end
      end
      MAC: begin
        if (k == CNT_W'(TAPS)) begin
          load_out = 1'b1;
          state_n  = OUT;
        end else begin
          mac_en = 1'b1;
        end
      end
      OUT: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/fir_mac_multich.sv
// Multichannel serial-MAC FIR: per-channel delay lines, shared coefficients,
// one multiply-accumulate per cycle, full-precision output.
module fir_mac_multich
  import fir_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int COEF_W   = 16,
  parameter int TAPS     = 64,
  parameter int CHANNELS = 2,
  parameter int OUT_W    = 38
) (
  input logic              clk,
  input logic              rst,
  fir_mac_multich_if.slave bus
);

  localparam int CH_W   = chan_w(CHANNELS);
  localparam int AW     = $clog2(TAPS);
  localparam int CNT_W  = cnt_w(TAPS);
  localparam int PROD_W = IN_W + COEF_W;

  if (OUT_W < fir_out_w(IN_W, COEF_W, TAPS)) begin : g_out_w_check
    $error("fir_mac_multich: OUT_W too narrow for IN_W+COEF_W+clog2(TAPS)");
  end

  logic signed [IN_W-1:0]   x [CHANNELS][TAPS];
  logic signed [COEF_W-1:0] h [TAPS];
  logic signed [OUT_W-1:0]  acc;
  logic signed [OUT_W-1:0]  out_data;
  logic [CH_W-1:0]          ch;
  logic [CH_W-1:0]          out_chan;
  logic signed [PROD_W-1:0] prod;
  logic signed [OUT_W-1:0]  prod_ext;
  logic [CNT_W-1:0]         k;
  logic [AW-1:0]            tap;
  logic chan_ok, addr_ok;
  logic accept, coef_wr, flush_en, mac_en, load_out;

  assign chan_ok  = int'(bus.in_chan) < CHANNELS;
  assign addr_ok  = int'(bus.coef_addr) < TAPS;
  assign tap      = k[AW-1:0];
  assign prod     = x[ch][tap] * h[tap];
  assign prod_ext = {{(OUT_W-PROD_W){prod[PROD_W-1]}}, prod};

  fir_mac_ctrl #(.TAPS(TAPS), .CNT_W(CNT_W)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (bus.in_valid),
    .chan_ok    (chan_ok),
    .coef_we    (bus.coef_we),
    .flush      (bus.flush),
    .out_ready  (bus.out_ready),
    .in_ready   (bus.in_ready),
    .coef_ready (bus.coef_ready),
    .out_valid  (bus.out_valid),
    .chan_err   (bus.chan_err),
    .accept     (accept),
    .coef_wr    (coef_wr),
    .flush_en   (flush_en),
    .mac_en     (mac_en),
    .load_out   (load_out),
    .k          (k)
  );

  assign bus.out_data = out_data;
  assign bus.out_chan = out_chan;

  // Delay lines: flush clears every channel, an accepted sample shifts its own channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush_en) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < TAPS; i++)
          x[c][i] <= '0;
    end else if (accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (CH_W'(c) == bus.in_chan) begin
          for (int i = TAPS-1; i > 0; i--) x[c][i] <= x[c][i-1];
          x[c][0] <= bus.in_data;
        end
      end
    end
  end

  // Coefficient register file, writable only while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) h[i] <= '0;
    end else if (coef_wr && addr_ok) begin
      h[bus.coef_addr] <= bus.coef_data;
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      ch       <= '0;
      out_data <= '0;
      out_chan <= '0;
    end else begin
      if (accept) begin
        acc <= '0;
        ch  <= bus.in_chan;
      end else if (mac_en) begin
        acc <= acc + prod_ext;
      end
      if (load_out) begin
        out_data <= acc;
        out_chan <= ch;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_multich.sv
// Scoreboard bench for fir_mac_multich (TAPS=64, CHANNELS=3 so that an
// out-of-range channel code exists on the 2-bit channel bus).
module tb_fir_mac_multich;

  localparam int IN_W     = 16;
  localparam int COEF_W   = 16;
  localparam int TAPS     = 64;
  localparam int CHANNELS = 3;
  localparam int OUT_W    = 38;
  localparam int CH_W     = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fir_mac_multich_if #(.IN_W(IN_W), .COEF_W(COEF_W), .TAPS(TAPS),
                       .CHANNELS(CHANNELS), .OUT_W(OUT_W)) bus ();

  fir_mac_multich #(.IN_W(IN_W), .COEF_W(COEF_W), .TAPS(TAPS),
                    .CHANNELS(CHANNELS), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic signed [OUT_W-1:0] d;
    logic [CH_W-1:0]         c;
    int                      acc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare every accepted result against the head of the queue.
  logic prev_v   = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (bus.out_valid && !prev_v) rise_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got data %0d chan %0d, expected no output",
                   bus.out_data, bus.out_chan);
        end else begin
          e = sbq.pop_front();
          chk("out_data", bus.out_data, e.d);
          chk("out_chan", 64'(bus.out_chan), 64'(e.c));
          chk("latency", 64'(rise_cyc - e.acc), 64'(TAPS + 1));
        end
      end
    end
    prev_v = bus.out_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [IN_W-1:0] d, input logic [CH_W-1:0] c,
                      input bit push, input logic signed [OUT_W-1:0] e);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_chan  = c;
    while (!bus.in_ready && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stayed %0d, expected 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    if (push) sbq.push_back('{e, c, cyc});
  endtask

  task automatic wcoef(input int a, input logic signed [COEF_W-1:0] d);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 6'(a);
    bus.coef_data = d;
    step();
    bus.coef_we   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
    end
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_chan   = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    chk("rst_coef_ready", 64'(bus.coef_ready), 1);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_chan", 64'(bus.out_chan), 0);
    chk("rst_chan_err", 64'(bus.chan_err), 0);
    step();
    rst = 1'b1;
    step();

    // Impulse response: h[k]=k+1, one then 63 zeros on ch0
    for (int i = 0; i < TAPS; i++) wcoef(i, 16'(i + 1));
    for (int j = 0; j < TAPS; j++) send((j == 0) ? 16'sd1 : 16'sd0, 2'd0, 1'b1, 38'(j + 1));
    drain();

    // Full scale on a fresh channel: partial sums (j+1)*2^30, last one 2^36
    for (int i = 0; i < TAPS; i++) wcoef(i, -16'sd32768);
    for (int j = 0; j < TAPS; j++) send(-16'sd32768, 2'd1, 1'b1, 38'(longint'(j + 1) <<< 30));
    drain();

    // Channel independence with h[0]=1 only
    wcoef(0, 16'sd1);
    for (int i = 1; i < TAPS; i++) wcoef(i, 16'sd0);
    for (int r = 0; r < 3; r++) begin
      send(16'sd100, 2'd0, 1'b1, 38'sd100);
      send(-16'sd7, 2'd1, 1'b1, -38'sd7);
    end
    drain();

    // Backpressure: result held, second sample waits for the handshake
    bus.out_ready = 1'b0;
    send(16'sd11, 2'd0, 1'b1, 38'sd11);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      step();
      n++;
    end
    chk("bp_out_valid_rise", 64'(bus.out_valid), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd22;
    bus.in_chan  = 2'd1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_hold_valid", 64'(bus.out_valid), 1);
      chk("bp_hold_data", bus.out_data, 11);
      chk("bp_in_ready", 64'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    chk("bp_release_in_ready", 64'(bus.in_ready), 0);
    step();
    chk("bp_idle_in_ready", 64'(bus.in_ready), 1);
    chk("bp_idle_out_valid", 64'(bus.out_valid), 0);
    step();
    chk("bp_second_accepted", 64'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    sbq.push_back('{38'sd22, 2'd1, cyc});
    drain();

    // Delay-line history, coef write and flush ignored during MAC
    wcoef(0, 16'sd0);
    wcoef(1, 16'sd1);
    send(16'sd5, 2'd0, 1'b1, 38'sd11);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 6'd1;
    bus.coef_data = 16'sd77;
    chk("mac_coef_ready", 64'(bus.coef_ready), 0);
    chk("mac_in_ready", 64'(bus.in_ready), 0);
    step();
    bus.coef_we = 1'b0;
    bus.flush   = 1'b1;
    step();
    bus.flush   = 1'b0;
    drain();
    send(16'sd9, 2'd1, 1'b1, 38'sd22);
    send(16'sd6, 2'd0, 1'b1, 38'sd5);
    drain();

    // Flush in IDLE beats the simultaneous coef write and sample
    for (int i = 0; i < TAPS; i++) wcoef(i, 16'(i + 1));
    bus.flush     = 1'b1;
    bus.coef_we   = 1'b1;
    bus.coef_addr = 6'd0;
    bus.coef_data = 16'sd1000;
    bus.in_valid  = 1'b1;
    bus.in_chan   = 2'd0;
    bus.in_data   = 16'sd50;
    chk("flush_in_ready", 64'(bus.in_ready), 1);
    step();
    bus.flush    = 1'b0;
    bus.coef_we  = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("flush_stays_idle", 64'(bus.in_ready), 1);
    send(16'sd1, 2'd0, 1'b1, 38'sd1);
    send(16'sd2, 2'd1, 1'b1, 38'sd2);
    drain();

    // Out-of-range channel: single chan_err pulse, nothing produced
    chk("err_idle_low", 64'(bus.chan_err), 0);
    bus.in_valid = 1'b1;
    bus.in_chan  = 2'd3;
    bus.in_data  = 16'sd123;
    step();
    bus.in_valid = 1'b0;
    chk("err_pulse", 64'(bus.chan_err), 1);
    chk("err_in_ready", 64'(bus.in_ready), 1);
    step();
    chk("err_pulse_end", 64'(bus.chan_err), 0);
    repeat (70) step();

    // Reset in the middle of a MAC run
    send(16'sd7, 2'd0, 1'b0, 38'sd0);
    repeat (30) step();
    rst = 1'b0;
    #1;
    chk("amid_out_valid", 64'(bus.out_valid), 0);
    chk("amid_in_ready", 64'(bus.in_ready), 1);
    chk("amid_coef_ready", 64'(bus.coef_ready), 1);
    chk("amid_out_data", bus.out_data, 0);
    chk("amid_out_chan", 64'(bus.out_chan), 0);
    chk("amid_chan_err", 64'(bus.chan_err), 0);
    step();
    rst = 1'b1;
    repeat (80) step();

    // Coefficients cleared by reset: only h[0] set again
    wcoef(0, 16'sd3);
    send(16'sd5, 2'd0, 1'b1, 38'sd15);
    send(16'sd4, 2'd0, 1'b1, 38'sd12);
    drain();

    repeat (3) step();
    chk("queue_empty", 64'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
